// File: rtl/rv32_lsu.sv
// rtl/rv32_lsu.sv - RV32I load/store unit with req/ack data-memory bus
//
// Purpose: takes the ALU effective address and rs2 store data, issues one
// word-aligned bus access with byte enables and lane-replicated write data,
// then aligns and sign/zero-extends the returned load data for writeback.
//
// Ports:
//   clk, rst                   core clock; asynchronous active-high reset
//   req_valid/req_ready        request handshake from the execute stage
//   req_we, req_funct3         store flag and RV32I funct3
//   req_addr, req_wdata        effective address and store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data; illegal/misaligned flag
//   mem_req/mem_we/mem_addr    bus request, held until mem_ack
//   mem_be/mem_wdata           byte enables and replicated write data
//   mem_ack/mem_rdata          bus completion and read word (same cycle)
//
// Configuration macro: RV32_LSU_MISALIGN_CHECK_EN
//   defined   - misaligned LH/LHU/SH/LW/SW are rejected with resp_err
//   undefined - misaligned low address bits are truncated

module rv32_lsu #(
  parameter int XLEN      = 32,
  parameter int ADDR_LSBS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;

  logic [1:0]        req_off;
  logic              funct3_ok;
  logic              misaligned;
  logic [3:0]        req_be;
  logic [XLEN-1:0]   req_lane_wdata;
  logic [XLEN-1:0]   byte_sh;
  logic [XLEN-1:0]   half_sh;
  logic [XLEN-1:0]   load_data;

  assign req_off = req_addr[1:0];

  // Legal encodings: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW.
  always_comb begin
    funct3_ok = 1'b0;
    if (req_we) begin
      funct3_ok = (req_funct3 <= 3'd2);
    end else begin
      funct3_ok = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) &&
                  (req_funct3 != 3'd7);
    end
  end

`ifdef RV32_LSU_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misaligned = req_off[0];
      2'd2:    misaligned = (req_off != 2'd0);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Size from funct3[1:0]; halfword lane ignores off[0] so a misaligned
  // half is truncated to its containing aligned half.
  always_comb begin
    req_be         = 4'b1111;
    req_lane_wdata = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        req_be         = 4'b0001 << req_off;
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_be         = 4'b0011 << {req_off[1], 1'b0};
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
      end
    endcase
  end

  // Load alignment uses the offset captured at issue time.
  assign byte_sh = mem_rdata >> {off_q, 3'b000};
  assign half_sh = mem_rdata >> {off_q[1], 4'b0000};

  always_comb begin
    load_data = mem_rdata;
    case (funct3_q)
      3'd0:    load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'd1:    load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'd4:    load_data = {24'd0, byte_sh[7:0]};
      3'd5:    load_data = {16'd0, half_sh[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  assign req_ready = (state_q == IDLE) || (state_q == RESP);

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      BUS: begin
        // Bus outputs hold until the ack; the ack cycle launches the response.
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? '0 : load_data;
        end
      end
      default: begin
        // IDLE and RESP both accept; mem_ack here is stale and ignored.
        state_d = IDLE;
        if (req_valid) begin
          if (!funct3_ok || misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = BUS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[XLEN-1:ADDR_LSBS], {ADDR_LSBS{1'b0}}};
            mem_be_d    = req_be;
            mem_wdata_d = req_lane_wdata;
            funct3_d    = req_funct3;
            off_d       = req_off;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_rv32_lsu.sv
// tb/tb_rv32_lsu.sv - directed table-driven bench for rv32_lsu

module tb_rv32_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_bus;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.funct3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(negedge clk);                       // cycle N+1
    req_valid = 1'b0;
    if (v.exp_bus) begin
      chk({v.name, " mem_req"},  {31'd0, mem_req},   32'd1);
      chk({v.name, " mem_we"},   {31'd0, mem_we},    {31'd0, v.we});
      chk({v.name, " mem_addr"}, mem_addr,           v.exp_addr);
      chk({v.name, " ready_bus"}, {31'd0, req_ready}, 32'd0);
      if (v.we) begin
        chk({v.name, " mem_be"},    {28'd0, mem_be}, {28'd0, v.exp_be});
        chk({v.name, " mem_wdata"}, mem_wdata,       v.exp_wdata);
      end
      for (int w = 0; w < v.waits; w++) begin
        @(negedge clk);
        chk({v.name, " wait_ready"}, {31'd0, req_ready}, 32'd0);
        chk({v.name, " wait_req"},   {31'd0, mem_req},   32'd1);
        chk({v.name, " wait_addr"},  mem_addr,           v.exp_addr);
        chk({v.name, " wait_resp"},  {31'd0, resp_valid}, 32'd0);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      chk({v.name, " mem_req_drop"}, {31'd0, mem_req}, 32'd0);
    end else begin
      chk({v.name, " no_mem_req"}, {31'd0, mem_req}, 32'd0);
    end
    chk({v.name, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({v.name, " resp_rdata"}, resp_rdata,          v.exp_rdata);
    chk({v.name, " resp_err"},   {31'd0, resp_err},   {31'd0, v.exp_err});
    @(negedge clk);
    chk({v.name, " resp_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    //        name        we    f3    addr          wdata         rdata         w  bus   exp_addr      be       exp_wdata     exp_rdata     err
    vecs[0]  = '{"SW",   1'b1, 3'd2, 32'h00000100, 32'hDEADBEEF, 32'h12345678, 0, 1'b1, 32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{"SB3",  1'b1, 3'd0, 32'h00000103, 32'h000000A5, 32'h0,        0, 1'b1, 32'h00000100, 4'b1000, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[2]  = '{"LB",   1'b0, 3'd0, 32'h00000102, 32'h0,        32'h12803456, 0, 1'b1, 32'h00000100, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[3]  = '{"LBU",  1'b0, 3'd4, 32'h00000102, 32'h0,        32'h12803456, 0, 1'b1, 32'h00000100, 4'b0000, 32'h0,        32'h00000080, 1'b0};
    vecs[4]  = '{"LH",   1'b0, 3'd1, 32'h00000202, 32'h0,        32'h80017FFF, 5, 1'b1, 32'h00000200, 4'b0000, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[5]  = '{"LHU",  1'b0, 3'd5, 32'h00000200, 32'h0,        32'h80017FFF, 1, 1'b1, 32'h00000200, 4'b0000, 32'h0,        32'h00007FFF, 1'b0};
    vecs[6]  = '{"SH",   1'b1, 3'd1, 32'h00000102, 32'h1234BEEF, 32'h0,        2, 1'b1, 32'h00000100, 4'b1100, 32'hBEEFBEEF, 32'h00000000, 1'b0};
    vecs[7]  = '{"LW",   1'b0, 3'd2, 32'h00000104, 32'h0,        32'hCAFEF00D, 0, 1'b1, 32'h00000104, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[8]  = '{"LD3",  1'b0, 3'd3, 32'h00000100, 32'h0,        32'h0,        0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h00000000, 1'b1};
    vecs[9]  = '{"ST4",  1'b1, 3'd4, 32'h00000100, 32'h11111111, 32'h0,        0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h00000000, 1'b1};
`ifdef RV32_LSU_MISALIGN_CHECK_EN
    vecs[10] = '{"LWMIS", 1'b0, 3'd2, 32'h00000101, 32'h0,       32'h11223344, 0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h00000000, 1'b1};
`else
    vecs[10] = '{"LWMIS", 1'b0, 3'd2, 32'h00000101, 32'h0,       32'h11223344, 0, 1'b1, 32'h00000100, 4'b0000, 32'h0,        32'h11223344, 1'b0};
`endif
    vecs[11] = '{"SB1",  1'b1, 3'd0, 32'h00000101, 32'h0000007F, 32'h0,        0, 1'b1, 32'h00000100, 4'b0010, 32'h7F7F7F7F, 32'h00000000, 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    #1;
    chk("rst ready",      {31'd0, req_ready},  32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata,          32'd0);
    chk("rst resp_err",   {31'd0, resp_err},   32'd0);
    chk("rst mem_req",    {31'd0, mem_req},    32'd0);
    chk("rst mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst mem_addr",   mem_addr,            32'd0);
    chk("rst mem_be",     {28'd0, mem_be},     32'd0);
    chk("rst mem_wdata",  mem_wdata,           32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // Back-to-back: accept a new request in the RESP cycle (throughput 1 per 2).
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h00000300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b mem_req1", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hA0B0C0D0;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("b2b resp1",    {31'd0, resp_valid}, 32'd1);
    chk("b2b rdata1",   resp_rdata,          32'hA0B0C0D0);
    chk("b2b ready_rsp", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h00000304; req_wdata = 32'h55AA55AA;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b mem_req2", {31'd0, mem_req},    32'd1);
    chk("b2b addr2",    mem_addr,            32'h00000304);
    chk("b2b wdata2",   mem_wdata,           32'h55AA55AA);
    chk("b2b noresp",   {31'd0, resp_valid}, 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b resp2",    {31'd0, resp_valid}, 32'd1);
    chk("b2b rdata2",   resp_rdata,          32'd0);

    // Reset mid-access: mem_req drops without a clock edge; late ack ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h00000400;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmid mem_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid drop",    {31'd0, mem_req},   32'd0);
    chk("rmid ready",   {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rmid noresp",  {31'd0, resp_valid}, 32'd0);
    chk("rmid nomreq",  {31'd0, mem_req},    32'd0);
    @(negedge clk);
    chk("rmid noresp2", {31'd0, resp_valid}, 32'd0);
    chk("rmid ready2",  {31'd0, req_ready},  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
